// File: rtl/slp_seq.sv
// Multi-output single-layer perceptron: sequential MAC over the input index with all
// neurons in parallel, handshaked in/out, on-line perceptron-rule training pass.
module slp_seq #(
    parameter int IN     = 8,
    parameter int OUT    = 4,
    parameter int I_PREC = 8,
    parameter int W_PREC = 8,
    parameter int R_PREC = 4,
    parameter int RESET  = 0,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset_,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN*I_PREC-1:0]   in,
    input  logic [OUT-1:0]         train,
    input  logic [R_PREC-1:0]      rate,
    input  logic                   t_en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT-1:0]         out,
    output logic [CNT_W-1:0]       err_cnt,
    input  logic                   err_clr
);

    localparam int ACC_W = I_PREC + W_PREC + $clog2(IN + 1) + 1;
    localparam int JW    = $clog2(IN + 1);
    localparam int UW    = W_PREC + I_PREC + R_PREC + 3;
    localparam logic signed [UW-1:0] W_MAX = UW'((2 ** (W_PREC - 1)) - 1);
    localparam logic signed [UW-1:0] W_MIN = ~W_MAX;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT, S_TRAIN} state_t;
    state_t state;

    logic signed [W_PREC-1:0] w      [OUT][IN+1];
    logic signed [I_PREC-1:0] x_lat  [IN+1];
    logic signed [ACC_W-1:0]  acc    [OUT];
    logic signed [ACC_W-1:0]  acc_nx [OUT];
    logic signed [UW-1:0]     sum    [OUT];
    logic signed [W_PREC-1:0] w_upd  [OUT];
    logic signed [UW-1:0]     delta;
    logic [OUT-1:0]           train_lat;
    logic [R_PREC-1:0]        rate_lat;
    logic                     t_en_lat;
    logic [JW-1:0]            j;
    logic                     last_j;
    logic                     mismatch;

    assign last_j   = (j == JW'(IN));
    assign mismatch = (out != train_lat);

    function automatic logic [31:0] xs_step(input logic [31:0] r);
        logic [31:0] t;
        t = r;
        t = t ^ (t << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    function automatic logic signed [W_PREC-1:0] w_init(input int unsigned k);
        logic [31:0] r;
        r = 32'd2463534242;
        case (RESET)
            1: return {1'b0, {(W_PREC-1){1'b1}}};
            2: return {1'b1, {(W_PREC-1){1'b0}}};
            3: begin
                for (int unsigned i = 0; i <= k; i++) r = xs_step(r);
                return r[W_PREC-1:0];
            end
            default: return '0;
        endcase
    endfunction

    // x_lat[IN] holds the constant 1 so the bias shares the MAC and training datapath.
    always_comb begin
        delta = UW'($signed({1'b0, rate_lat})) * UW'(x_lat[j]);
        for (int unsigned n = 0; n < OUT; n++) begin
            acc_nx[n] = acc[n] + ACC_W'(w[n][j]) * ACC_W'(x_lat[j]);
            if (train_lat[n] && !out[n])
                sum[n] = UW'(w[n][j]) + delta;
            else if (!train_lat[n] && out[n])
                sum[n] = UW'(w[n][j]) - delta;
            else
                sum[n] = UW'(w[n][j]);
            if (sum[n] > W_MAX)
                w_upd[n] = W_MAX[W_PREC-1:0];
            else if (sum[n] < W_MIN)
                w_upd[n] = W_MIN[W_PREC-1:0];
            else
                w_upd[n] = sum[n][W_PREC-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out       <= '0;
            err_cnt   <= '0;
            j         <= '0;
            train_lat <= '0;
            rate_lat  <= '0;
            t_en_lat  <= 1'b0;
            for (int unsigned n = 0; n < OUT; n++) begin
                acc[n] <= '0;
                for (int unsigned k = 0; k <= IN; k++)
                    w[n][k] <= w_init(n * (IN + 1) + k);
            end
            for (int unsigned k = 0; k <= IN; k++) x_lat[k] <= '0;
        end else begin
            if (err_clr)
                err_cnt <= '0;
            else if (state == S_OUT && out_ready && mismatch && err_cnt != '1)
                err_cnt <= err_cnt + 1'b1;

            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        for (int unsigned k = 0; k < IN; k++)
                            x_lat[k] <= in[k*I_PREC +: I_PREC];
                        x_lat[IN] <= I_PREC'(1);
                        train_lat <= train;
                        rate_lat  <= rate;
                        t_en_lat  <= t_en;
                        for (int unsigned n = 0; n < OUT; n++) acc[n] <= '0;
                        j        <= '0;
                        in_ready <= 1'b0;
                        state    <= S_MAC;
                    end
                end
                S_MAC: begin
                    for (int unsigned n = 0; n < OUT; n++) acc[n] <= acc_nx[n];
                    if (last_j) begin
                        for (int unsigned n = 0; n < OUT; n++) out[n] <= ~acc_nx[n][ACC_W-1];
                        out_valid <= 1'b1;
                        j         <= '0;
                        state     <= S_OUT;
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        j         <= '0;
                        if (t_en_lat && mismatch) begin
                            state <= S_TRAIN;
                        end else begin
                            state    <= S_IDLE;
                            in_ready <= 1'b1;
                        end
                    end
                end
                S_TRAIN: begin
                    for (int unsigned n = 0; n < OUT; n++) w[n][j] <= w_upd[n];
                    if (last_j) begin
                        j        <= '0;
                        in_ready <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/slp_seq.md
Name: slp_seq

Overview:
- Multi-output single-layer perceptron with a handshaked stream interface. Uses sequential multiply-accumulate: one weight index per cycle, all OUT neurons in parallel.
- Supports on-line perceptron-rule training as a separate sequential update pass, four weight-reset modes and a saturating misprediction counter.
- Sits between a sample source and a classifier consumer. It is the next generation of the combinational single-neuron perceptron: multi-channel, pipelined/time-multiplexed, with flow control.

Parameters:
- IN, 8, number of inputs per sample (>=1).
- OUT, 4, number of neurons/output bits (>=1).
- I_PREC, 8, input width, signed two's complement integer.
- W_PREC, 8, weight width, signed two's complement integer.
- R_PREC, 4, learning-rate width, unsigned integer.
- RESET, 0, weight reset mode: 0 zero, 1 signed max, 2 signed min, 3 xorshift.
- CNT_W, 16, misprediction counter width.
- ACC_W, I_PREC+W_PREC+$clog2(IN+1)+1, accumulator width (derived, not overridden).

Ports:
- clk  in  1  clock.
- reset_  in  1  asynchronous active-low reset.
- in_valid  in  1  sample valid.
- in_ready  out  1  block can accept a sample.
- in  in  IN*I_PREC  packed signed inputs, element j at [j*I_PREC +: I_PREC].
- train  in  OUT  target class bits.
- rate  in  R_PREC  learning rate.
- t_en  in  1  train on this sample.
- out_valid  out  1  prediction valid.
- out_ready  in  1  consumer accepts prediction.
- out  out  OUT  predicted class bits.
- err_cnt  out  CNT_W  saturating count of samples with out!=train.
- err_clr  in  1  synchronous clear of err_cnt.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low on reset_.
  - Reset values: state IDLE, in_ready=1, out_valid=0, out=0, err_cnt=0, acc=0.
  - Weights reset per RESET mode. Weight index k = n*(IN+1)+j; j=IN is the bias.
  - Mode 3: r=32'd2463534242; apply (r^=r<<13; r^=r>>17; r^=r<<5) k+1 times; weight = r[W_PREC-1:0].
- States: IDLE, MAC, OUT, TRAIN.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge E: latch in, train, rate, t_en; clear acc[n]; j=0; go MAC.
- MAC:
  - Each edge: acc[n] += w[n][j]*x_j, with x_j=in_j for j<IN and x_IN=1. Then j++.
  - Full precision, no overflow possible in ACC_W.
  - The edge processing j=IN also registers out[n] = (final acc[n] >= 0). out_valid rises at edge E+IN+1, i.e. latency IN+1 cycles.
- OUT:
  - out_valid=1; out and out_valid held stable while out_ready=0. in_ready=0.
  - On out_valid&&out_ready:
    - err_cnt += 1 if out!=train_latched (saturates at all-ones).
    - If t_en_latched and out!=train_latched: go TRAIN with j=0. Else go IDLE.
- TRAIN:
  - IN+1 cycles, index j per edge, all neurons in parallel.
  - e_n = train[n]-out[n] in {-1,0,+1}.
  - w[n][j] <= sat_W(w[n][j] + e_n*rate*x_j), computed at full width then clamped to [-2^(W_PREC-1), 2^(W_PREC-1)-1].
  - After j=IN: go IDLE. in_ready=0 throughout.
- err_clr: has priority over an increment in the same cycle; counter becomes 0.
- No new sample is accepted before the output handshake and any training pass complete. A back-to-back sample is accepted at the first IDLE edge.
- Reset mid-operation (any state): returns immediately to reset values; the partially updated weights are discarded and reinitialised.
- rate=0 with t_en=1 and an error: TRAIN pass still runs IN+1 cycles, weights unchanged, err_cnt increments.

Test Plan:
- Latency/handshake: IN=2, OUT=1, I_PREC=W_PREC=8, RESET=0; in=(3,-2), out_ready=1 -> out_valid rises 3 cycles after acceptance, out=1 (acc=0).
- Training: same sample, train=0, rate=1, t_en=1 -> TRAIN 3 cycles, weights (w0,w1,b)=(-3,2,-1), err_cnt=1. Resend -> acc=-14, out=0, no TRAIN, err_cnt stays 1.
- Saturation: w0=0, x0=127, rate=15, e=-1, repeated 1 time -> w0=-128, not wraparound. A further identical error keeps -128.
- Backpressure: hold out_ready=0 for 5 cycles -> out and out_valid stable, in_ready=0, and in_valid pulses ignored.
- Reset: assert reset_ mid-TRAIN -> out_valid=0, in_ready=1, err_cnt=0, weights equal mode value. RESET=3 weights match the xorshift model for every k.
- Counter: set err_cnt to all-ones via CNT_W=2 and 4 errors -> holds 3. err_clr coincident with an error -> 0.
